ahb_vga_write_buffer: RTL

//  Posted-write buffer between the AHB-Lite interconnect and the VGA peripheral slave.

---
 rtl/ahb_vga_write_buffer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ahb_vga_write_buffer.sv
// Posted-write buffer in front of the VGA slave: CPU writes land in a FIFO with no
// wait states and are replayed downstream as single non-pipelined AHB writes.
//
// state | meaning
// IDLE  | nothing in flight, waiting for a queued write
// ADDR  | downstream address phase for the head entry
// DATA  | downstream data phase; head is popped when the slave is ready
module ahb_vga_write_buffer #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned DATA_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h5000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        M_HSEL,
  output logic [31:0] M_HADDR,
  output logic        M_HWRITE,
  output logic [1:0]  M_HTRANS,
  output logic [31:0] M_HWDATA,
  output logic        M_HREADY,
  input  logic        M_HREADYOUT,
  output logic        wb_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                dp_valid_q, dp_valid_d;
  logic                dp_wr_q, dp_wr_d;
  logic [ADDR_W-1:0]   dp_addr_q, dp_addr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [31:0]         m_haddr_q, m_haddr_d;
  logic [31:0]         m_hwdata_q, m_hwdata_d;
  logic [ENT_W-1:0]    mem_q [DEPTH];

  logic                full, empty, push, pop;
  logic [ENT_W-1:0]    push_entry, head_entry, next_entry, issue_entry;
  logic [7:0]          level_sat;
  logic                unused_bits;

  assign unused_bits = ^{HADDR[31:ADDR_W], HWDATA[31:DATA_W], HTRANS[0]};

  // Full uses the registered level only, so a pop never unblocks a push in the same cycle.
  assign full       = (level_q == LVL_W'(DEPTH));
  assign empty      = (level_q == '0);
  assign push       = dp_valid_q & dp_wr_q & ~full;
  assign pop        = (state_q == ST_DATA) & M_HREADYOUT & ~empty;
  assign push_entry = {dp_addr_q, HWDATA[DATA_W-1:0]};
  assign head_entry = mem_q[rd_ptr_q];
  assign next_entry = mem_q[rd_ptr_q + PTR_W'(1)];

  // Entry loaded into M_HADDR on entering ADDR; bypasses the FIFO when it is being pushed now.
  always_comb begin
    issue_entry = push_entry;
    if (state_q == ST_IDLE) begin
      if (!empty) issue_entry = head_entry;
    end else if (level_q > LVL_W'(1)) begin
      issue_entry = next_entry;
    end
  end

  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_wr_d    = dp_wr_q;
    dp_addr_d  = dp_addr_q;
    if (HREADY) begin
      dp_valid_d = HSEL & HTRANS[1];
      dp_wr_d    = HWRITE;
      dp_addr_d  = HADDR[ADDR_W-1:0];
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge HCLK) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      dp_valid_q <= 1'b0;
      dp_wr_q    <= 1'b0;
      dp_addr_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      m_haddr_q  <= '0;
      m_hwdata_q <= '0;
    end else begin
      state_q    <= state_d;
      dp_valid_q <= dp_valid_d;
      dp_wr_q    <= dp_wr_d;
      dp_addr_q  <= dp_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      m_haddr_q  <= m_haddr_d;
      m_hwdata_q <= m_hwdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    m_haddr_d  = m_haddr_q;
    m_hwdata_d = m_hwdata_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty || push) begin
          state_d   = ST_ADDR;
          m_haddr_d = BASE_ADDR | 32'(issue_entry[ENT_W-1:DATA_W]);
        end
      end
      ST_ADDR: begin
        if (M_HREADYOUT) begin
          state_d    = ST_DATA;
          m_hwdata_d = 32'(head_entry[DATA_W-1:0]);
        end
      end
      ST_DATA: begin
        if (M_HREADYOUT) begin
          if (level_q > LVL_W'(1) || push) begin
            state_d   = ST_ADDR;
            m_haddr_d = BASE_ADDR | 32'(issue_entry[ENT_W-1:DATA_W]);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    level_sat = (32'(level_q) > 32'd255) ? 8'hFF : 8'(level_q);
    HREADYOUT = ~(dp_valid_q & dp_wr_q & full);
    HRDATA    = {16'h0, level_sat, 6'h0, full, empty};
    M_HSEL    = (state_q == ST_ADDR);
    M_HWRITE  = (state_q == ST_ADDR);
    M_HTRANS  = (state_q == ST_ADDR) ? 2'b10 : 2'b00;
    wb_empty  = empty & (state_q == ST_IDLE);
  end

  assign M_HADDR   = m_haddr_q;
  assign M_HWDATA  = m_hwdata_q;
  assign M_HREADY  = M_HREADYOUT;

endmodule
